// File: rtl/alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_seq                                                          |
// | Brief   : Handshaked SPARC format-3 integer ALU with iterative MUL/DIV,    |
// |           Y register, icc and divide-by-zero flag. Define                  |
// |           ALU_SEQ_FAST_MUL_EN for a single-cycle multiplier.               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [5:0]       op3,
    input  logic             i,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [12:0]      simm13,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] y_out,
    output logic [3:0]       icc,
    output logic             icc_we,
    output logic             div_zero,
    output logic             illegal
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_and  = 4'b0001;
    localparam logic [3:0] c_op_or   = 4'b0010;
    localparam logic [3:0] c_op_xor  = 4'b0011;
    localparam logic [3:0] c_op_sub  = 4'b0100;
    localparam logic [3:0] c_op_xnor = 4'b0111;
    localparam logic [3:0] c_op_umul = 4'b1010;
    localparam logic [3:0] c_op_smul = 4'b1011;
    localparam logic [3:0] c_op_udiv = 4'b1110;
    localparam logic [3:0] c_op_sdiv = 4'b1111;

    localparam logic [WIDTH-1:0] c_ones    = '1;
    localparam logic [WIDTH-1:0] c_min     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_max     = ~c_min;
    localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [1:0]         r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_a, r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg, r_cc, r_div0, r_ovf;
    logic [WIDTH-1:0]   r_res, r_y;
    logic [3:0]         r_icc;
    logic               r_icc_we, r_div_zero, r_illegal;

    logic               w_alu, w_legal, w_is_mul, w_is_div, w_signed, w_cc, w_accept;
    logic               w_a_neg, w_b_neg, w_neg;
    logic [WIDTH-1:0]   w_b, w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_sum, w_diff;

    logic [2*WIDTH-1:0] w_mul_acc, w_prod;
    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_nxt, w_q_nxt, w_quot;

    logic               w_fin;
    logic [WIDTH-1:0]   w_fin_res, w_fin_y;
    logic               w_fin_v, w_fin_c, w_fin_divz, w_fin_ill, w_fin_ccwe, w_fin_ywe;
    logic [3:0]         w_fin_icc;

    // Operand decode
    assign w_b = i ? {{(WIDTH-13){simm13[12]}}, simm13} : valB;
    assign w_alu = (op == 2'b10);

    always_comb begin
        w_legal = 1'b0;
        if (w_alu && !op3[5]) begin
            case (op3[3:0])
                c_op_add, c_op_and, c_op_or, c_op_xor, c_op_sub, c_op_xnor,
                c_op_umul, c_op_smul, c_op_udiv, c_op_sdiv: w_legal = 1'b1;
                default: w_legal = 1'b0;
            endcase
        end
    end

    assign w_is_mul = w_legal && (op3[3:1] == 3'b101);
    assign w_is_div = w_legal && (op3[3:1] == 3'b111);
    assign w_signed = op3[0];
    assign w_cc     = w_legal && op3[4];
    assign w_accept = in_valid && in_ready;

    // MUL/DIV run on magnitudes; the sign is reapplied on completion
    assign w_a_neg = w_signed && valA[WIDTH-1];
    assign w_b_neg = w_signed && w_b[WIDTH-1];
    assign w_neg   = w_a_neg ^ w_b_neg;
    assign w_a_mag = w_a_neg ? -valA : valA;
    assign w_b_mag = w_b_neg ? -w_b : w_b;

    assign w_sum  = {1'b0, valA} + {1'b0, w_b};
    assign w_diff = {1'b0, valA} - {1'b0, w_b};

`ifdef ALU_SEQ_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_mag, w_fast_prod;
    assign w_fast_mag  = {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
    assign w_fast_prod = w_neg ? -w_fast_mag : w_fast_mag;
`endif

    // Iterative engines: the last step feeds the result directly
    assign w_mul_acc = r_b[0] ? (r_acc + r_a) : r_acc;
    assign w_prod    = r_neg ? -w_mul_acc : w_mul_acc;
    assign w_trial   = {r_acc[WIDTH-1:0], r_a[WIDTH-1]};
    assign w_fits    = (w_trial >= {1'b0, r_b});
    assign w_rem_nxt = w_fits ? (w_trial[WIDTH-1:0] - r_b) : w_trial[WIDTH-1:0];
    assign w_q_nxt   = {r_a[WIDTH-2:0], w_fits};
    assign w_quot    = r_neg ? -w_q_nxt : w_q_nxt;

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    if (w_is_div)      w_state_nxt = c_st_div;
`ifndef ALU_SEQ_FAST_MUL_EN
                    else if (w_is_mul) w_state_nxt = c_st_mul;
`endif
                    else               w_state_nxt = c_st_done;
                end
            end
            c_st_mul:  if (r_cnt == c_last) w_state_nxt = c_st_done;
            c_st_div:  if (r_div0 || (r_cnt == c_last)) w_state_nxt = c_st_done;
            c_st_done: if (out_ready) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        out_valid = (r_state == c_st_done);
        in_ready  = (r_state == c_st_idle) && !out_valid;
    end

    // Result and flags captured on the transition into DONE
    assign w_fin = (r_state != c_st_done) && (w_state_nxt == c_st_done);

    always_comb begin
        w_fin_res  = '0;
        w_fin_y    = '0;
        w_fin_v    = 1'b0;
        w_fin_c    = 1'b0;
        w_fin_divz = 1'b0;
        w_fin_ill  = 1'b0;
        w_fin_ccwe = 1'b0;
        w_fin_ywe  = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_fin_ill  = w_alu && !w_legal;
                w_fin_ccwe = w_cc;
                if (w_legal) begin
                    case (op3[3:0])
                        c_op_add: begin
                            w_fin_res = w_sum[WIDTH-1:0];
                            w_fin_c   = w_sum[WIDTH];
                            w_fin_v   = (valA[WIDTH-1] == w_b[WIDTH-1]) &&
                                        (w_sum[WIDTH-1] != valA[WIDTH-1]);
                        end
                        c_op_sub: begin
                            w_fin_res = w_diff[WIDTH-1:0];
                            w_fin_c   = w_diff[WIDTH];
                            w_fin_v   = (valA[WIDTH-1] != w_b[WIDTH-1]) &&
                                        (w_diff[WIDTH-1] != valA[WIDTH-1]);
                        end
                        c_op_and:  w_fin_res = valA & w_b;
                        c_op_or:   w_fin_res = valA | w_b;
                        c_op_xor:  w_fin_res = valA ^ w_b;
                        c_op_xnor: w_fin_res = ~(valA ^ w_b);
`ifdef ALU_SEQ_FAST_MUL_EN
                        c_op_umul, c_op_smul: begin
                            w_fin_res = w_fast_prod[WIDTH-1:0];
                            w_fin_y   = w_fast_prod[2*WIDTH-1:WIDTH];
                            w_fin_ywe = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            c_st_mul: begin
                w_fin_res  = w_prod[WIDTH-1:0];
                w_fin_y    = w_prod[2*WIDTH-1:WIDTH];
                w_fin_ywe  = 1'b1;
                w_fin_ccwe = r_cc;
            end
            c_st_div: begin
                w_fin_ccwe = r_cc;
                if (r_div0) begin
                    w_fin_res  = c_ones;
                    w_fin_divz = 1'b1;
                end else if (r_ovf) begin
                    w_fin_res = c_max;
                    w_fin_v   = 1'b1;
                end else begin
                    w_fin_res = w_quot;
                end
            end
            default: ;
        endcase
    end

    assign w_fin_icc = {w_fin_res[WIDTH-1], (w_fin_res == '0), w_fin_v, w_fin_c};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_acc      <= '0;
            r_b        <= '0;
            r_neg      <= 1'b0;
            r_cc       <= 1'b0;
            r_div0     <= 1'b0;
            r_ovf      <= 1'b0;
            r_res      <= '0;
            r_y        <= '0;
            r_icc      <= '0;
            r_icc_we   <= 1'b0;
            r_div_zero <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            if (w_fin) begin
                r_res      <= w_fin_res;
                r_icc_we   <= w_fin_ccwe;
                r_div_zero <= w_fin_divz;
                r_illegal  <= w_fin_ill;
                if (w_fin_ccwe) r_icc <= w_fin_icc;
                if (w_fin_ywe)  r_y   <= w_fin_y;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_a    <= {{WIDTH{1'b0}}, w_a_mag};
                        r_acc  <= '0;
                        r_b    <= w_b_mag;
                        r_neg  <= w_neg;
                        r_cc   <= w_cc;
                        r_cnt  <= '0;
                        r_div0 <= w_is_div && (w_b == '0);
                        r_ovf  <= w_is_div && w_signed && (valA == c_min) && (w_b == c_ones);
                    end
                end
                c_st_mul: begin
                    r_acc <= w_mul_acc;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + c_cnt_one;
                end
                c_st_div: begin
                    r_acc[WIDTH-1:0] <= w_rem_nxt;
                    r_a[WIDTH-1:0]   <= w_q_nxt;
                    r_cnt            <= r_cnt + c_cnt_one;
                end
                default: ;
            endcase
        end
    end

    assign res      = r_res;
    assign y_out    = r_y;
    assign icc      = r_icc;
    assign icc_we   = r_icc_we;
    assign div_zero = r_div_zero;
    assign illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_seq                                                       |
// | Brief   : Randomised self-checking bench for alu_seq against an            |
// |           arithmetic reference model.                                      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_alu_seq;

    localparam int W = 32;
`ifdef ALU_SEQ_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    op = 2'b00;
    logic [5:0]    op3 = 6'h00;
    logic          i = 1'b0;
    logic [W-1:0]  valA = '0;
    logic [W-1:0]  valB = '0;
    logic [12:0]   simm13 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  res;
    logic [W-1:0]  y_out;
    logic [3:0]    icc;
    logic          icc_we;
    logic          div_zero;
    logic          illegal;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] m_y   = '0;
    logic [3:0]   m_icc = '0;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .op3      (op3),
        .i        (i),
        .valA     (valA),
        .valB     (valB),
        .simm13   (simm13),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .res      (res),
        .y_out    (y_out),
        .icc      (icc),
        .icc_we   (icc_we),
        .div_zero (div_zero),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural definition
    task automatic ref_model(input logic [1:0] f_op, input logic [5:0] f_op3, input logic f_i,
                             input logic [31:0] a, input logic [31:0] b_reg, input logic [12:0] imm,
                             output logic [31:0] r, output logic ccwe, output logic dz,
                             output logic ill, output int lat);
        logic [31:0] b;
        logic [63:0] p;
        longint      sa, sb, s;
        logic        v, c, ywe;
        b   = f_i ? {{19{imm[12]}}, imm} : b_reg;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = '0;
        p   = '0;
        v   = 1'b0;
        c   = 1'b0;
        dz  = 1'b0;
        ill = 1'b0;
        ywe = 1'b0;
        ccwe = 1'b0;
        lat = 1;
        if (f_op == 2'b10) begin
            ccwe = f_op3[4];
            if (f_op3[5]) ill = 1'b1;
            else begin
                case (f_op3[3:0])
                    4'h0: begin
                        p = {32'b0, a} + {32'b0, b};
                        r = p[31:0];
                        c = p[32];
                        s = sa + sb;
                        v = (s != longint'($signed(r)));
                    end
                    4'h1: r = a & b;
                    4'h2: r = a | b;
                    4'h3: r = a ^ b;
                    4'h7: r = ~(a ^ b);
                    4'h4: begin
                        r = a - b;
                        c = (a < b);
                        s = sa - sb;
                        v = (s != longint'($signed(r)));
                    end
                    4'hA: begin
                        p = {32'b0, a} * {32'b0, b};
                        r = p[31:0];
                        ywe = 1'b1;
                        lat = MUL_LAT;
                    end
                    4'hB: begin
                        s = sa * sb;
                        p = 64'(s);
                        r = p[31:0];
                        ywe = 1'b1;
                        lat = MUL_LAT;
                    end
                    4'hE: begin
                        if (b == 0) begin r = '1; dz = 1'b1; lat = 2; end
                        else begin r = a / b; lat = DIV_LAT; end
                    end
                    4'hF: begin
                        if (b == 0) begin r = '1; dz = 1'b1; lat = 2; end
                        else begin
                            s = sa / sb;
                            lat = DIV_LAT;
                            if (s != longint'($signed(s[31:0]))) begin r = 32'h7FFF_FFFF; v = 1'b1; end
                            else r = s[31:0];
                        end
                    end
                    default: ill = 1'b1;
                endcase
            end
            if (ill) begin r = '0; ccwe = 1'b0; ywe = 1'b0; lat = 1; end
            if (ywe)  m_y = p[63:32];
            if (ccwe) m_icc = {r[31], (r == 0), v, c};
        end
    endtask

    // Starts and ends at a falling edge with the DUT idle
    task automatic do_op(input logic [1:0] f_op, input logic [5:0] f_op3, input logic f_i,
                         input logic [31:0] a, input logic [31:0] b, input logic [12:0] imm,
                         input int hold);
        logic [31:0] e_res, held;
        logic        e_ccwe, e_dz, e_ill, busy_bad, hold_bad;
        int          e_lat, lat;
        ref_model(f_op, f_op3, f_i, a, b, imm, e_res, e_ccwe, e_dz, e_ill, e_lat);
        op = f_op; op3 = f_op3; i = f_i; valA = a; valB = b; simm13 = imm;
        in_valid = 1'b1;
        check_eq("in_ready_idle", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        valA = $urandom; valB = $urandom; simm13 = 13'($urandom);
        op3 = 6'($urandom); i = 1'($urandom); op = 2'($urandom);
        lat = 0;
        busy_bad = 1'b0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (in_ready) busy_bad = 1'b1;
            if (out_valid) break;
        end
        check_eq("latency", 64'(lat), 64'(e_lat));
        check_eq("in_ready_busy", 64'(busy_bad), 64'(0));
        check_eq("res", 64'(res), 64'(e_res));
        check_eq("y_out", 64'(y_out), 64'(m_y));
        check_eq("icc", 64'(icc), 64'(m_icc));
        check_eq("icc_we", 64'(icc_we), 64'(e_ccwe));
        check_eq("div_zero", 64'(div_zero), 64'(e_dz));
        check_eq("illegal", 64'(illegal), 64'(e_ill));
        held = res;
        hold_bad = 1'b0;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1; op = 2'b10; op3 = 6'h00; valA = $urandom;
            @(negedge clk);
            if (!out_valid || in_ready || (res !== held)) hold_bad = 1'b1;
        end
        in_valid = 1'b0;
        if (hold > 0) check_eq("hold_stable", 64'(hold_bad), 64'(0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("drained_valid", 64'(out_valid), 64'(0));
        check_eq("ready_after_drain", 64'(in_ready), 64'(1));
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] codes [10];
        logic [1:0] f_op;
        logic [5:0] f_op3;
        logic       saw;
        int         sel;
        codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'hA, 4'hB, 4'hE, 4'hF};

        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_res", 64'(res), 64'(0));
        check_eq("rst_y", 64'(y_out), 64'(0));
        check_eq("rst_icc", 64'(icc), 64'(0));
        check_eq("rst_flags", 64'({icc_we, div_zero, illegal}), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));

        do_op(2'b10, 6'h10, 1'b0, 32'h7FFF_FFFF, 32'h1, 13'h0, 0);
        do_op(2'b10, 6'h04, 1'b1, 32'd5, 32'hDEAD_BEEF, 13'h1FFF, 0);
        do_op(2'b10, 6'h14, 1'b0, 32'd3, 32'd5, 13'h0, 0);
        do_op(2'b10, 6'h0B, 1'b0, 32'hFFFF_FFFD, 32'd7, 13'h0, 0);
        do_op(2'b10, 6'h0E, 1'b0, 32'd100, 32'd0, 13'h0, 0);
        do_op(2'b10, 6'h1F, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 13'h0, 0);
        do_op(2'b10, 6'h03, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F, 13'h0, 10);
        do_op(2'b10, 6'h1A, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 13'h0, 0);
        do_op(2'b10, 6'h1F, 1'b1, 32'hFFFF_FF9C, 32'h0, 13'h0007, 0);
        do_op(2'b10, 6'h25, 1'b0, 32'd1, 32'd2, 13'h0, 0);
        do_op(2'b10, 6'h15, 1'b0, 32'd1, 32'd2, 13'h0, 0);
        do_op(2'b01, 6'h00, 1'b0, 32'd1, 32'd2, 13'h0, 0);

        // Abort a divide part-way through
        op = 2'b10; op3 = 6'h0E; i = 1'b0; valA = 32'd1000; valB = 32'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_y = '0;
        m_icc = '0;
        @(negedge clk);
        check_eq("abort_out_valid", 64'(out_valid), 64'(0));
        check_eq("abort_y", 64'(y_out), 64'(0));
        check_eq("abort_in_ready", 64'(in_ready), 64'(1));
        check_eq("abort_icc", 64'(icc), 64'(0));
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check_eq("abort_no_emit", 64'(saw), 64'(0));

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 19);
            f_op = 2'b10;
            if (sel < 16)      f_op3 = {1'b0, 1'($urandom), codes[$urandom_range(0, 9)]};
            else if (sel < 18) f_op3 = {1'b1, 5'($urandom)};
            else               f_op3 = 6'($urandom);
            if (sel == 19) begin
                f_op = 2'($urandom_range(0, 2));
                if (f_op == 2'b10) f_op = 2'b11;
            end
            do_op(f_op, f_op3, 1'($urandom), pick_val(), pick_val(), 13'($urandom),
                  (n % 7 == 0) ? 3 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle format-3 ALU in the execute stage.
- Executes SPARC format-3 integer ops (op=2'b10) with valid/ready on both sides.
- Single-cycle ops complete in 1 cycle. MUL/DIV run as WIDTH-cycle iterative engines.
- Adds a Y register, condition codes (icc) and a divide-by-zero flag.

Parameters:
- WIDTH, 32, datapath width; even, >=16.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, operation offered.
- in_ready, output, 1, operation accepted when in_valid && in_ready.
- op, input, 2, instruction op field.
- op3, input, 6, instruction op3 field.
- i, input, 1, 1 = use sign-extended simm13 as operand B.
- valA, input, WIDTH, rs1 value.
- valB, input, WIDTH, rs2 value.
- simm13, input, 13, immediate.
- out_valid, output, 1, result held valid.
- out_ready, input, 1, consumer takes result.
- res, output, WIDTH, result.
- y_out, output, WIDTH, current Y register.
- icc, output, 4, {N,Z,V,C} of last cc-op.
- icc_we, output, 1, result is a cc variant; qualified by out_valid.
- div_zero, output, 1, divide by zero; qualified by out_valid.
- illegal, output, 1, unsupported op3; qualified by out_valid.

Behaviour:
- Reset values: out_valid=0, res=0, y_out=0, icc=0, icc_we=0, div_zero=0, illegal=0, state IDLE, counter 0.
- Operand B: i ? sign-extend(simm13) to WIDTH : valB.
- op3 low 4 bits select the operation:
  - ADD 0000, AND 0001, OR 0010, XOR 0011, SUB 0100, XNOR 0111.
  - UMUL 1010, SMUL 1011, UDIV 1110, SDIV 1111.
- op3[4]=1 marks a cc variant. op3[5]=1 or any other code sets illegal=1, res=0, latency 1.
- op != 2'b10: nop, res=0, latency 1, no flags.
- State machine: IDLE -> (accept mul) MUL -> DONE; IDLE -> (accept div) DIV -> DONE; IDLE -> (accept other) DONE; DONE -> IDLE when out_ready.
- in_ready = (state==IDLE) && !out_valid. A new op is never accepted in the same cycle as a drain.
- out_valid=1 exactly in DONE. res and flags stay stable until out_ready.
- Latency from accept to out_valid:
  - 1 cycle for logic/add/sub/illegal/nop.
  - WIDTH+1 cycles for MUL and DIV.
- MUL: shift-add over magnitudes, one bit per cycle.
  - SMUL negates the 2W product when operand signs differ.
  - res = low WIDTH bits; Y = high WIDTH bits, updated at DONE entry.
- DIV: restoring divide of valA by B, one quotient bit per cycle.
  - SDIV truncates toward zero; remainder is discarded; Y is not written.
  - B==0: skip the iterations, go to DONE next cycle, res={WIDTH{1}}, div_zero=1.
  - SDIV of most-negative by -1: res=most-positive; V=1 if cc variant.
- icc, updated only when the cc variant completes:
  - N = res[MSB]; Z = (res==0).
  - ADD/SUB: V and C per SPARC (C = carry out for add, borrow for sub).
  - All other ops: V=0, C=0 (except SDIV overflow above).
- Operands are latched at accept. Input changes during MUL/DIV have no effect.
- Reset mid-MUL/DIV: operation aborted and nothing emitted; all registers return to reset values next cycle.
- out_ready held low: DONE persists indefinitely, no data loss.

Optional Feature:
- Macro ALU_SEQ_FAST_MUL_EN.
- Defined: MUL/SMUL use a single-cycle combinational multiplier. Latency 1, no MUL state. Results, Y and icc are identical to the iterative engine.
- Undefined: iterative multiplier, latency WIDTH+1.
- DIV is iterative in both builds.

Test Plan:
- ADDcc: valA=0x7FFFFFFF, valB=1, i=0 -> after 1 cycle res=0x80000000, icc=N1 Z0 V1 C0, icc_we=1.
- SUB immediate: valA=5, i=1, simm13=0x1FFF (-1) -> res=6. Then SUBcc 3-5 -> res=0xFFFFFFFE, icc N1 Z0 V0 C1.
- SMUL, WIDTH=32, macro off: valA=-3, valB=7 -> out_valid exactly 33 cycles after accept, res=0xFFFFFFEB, y_out=0xFFFFFFFF; in_ready=0 throughout.
- UDIV by zero: valA=100, valB=0 -> next-cycle-plus-one out_valid, res=0xFFFFFFFF, div_zero=1. SDIV 0x80000000 / -1 (cc variant) -> res=0x7FFFFFFF, V=1.
- Back-pressure: out_ready=0 for 10 cycles after XOR result -> res stable, in_ready=0, second op not accepted. Release -> second op accepted the cycle after the drain.
- Reset asserted on cycle 10 of a UDIV -> out_valid never rises; y_out=0 and in_ready=1 the cycle after reset deasserts.
